// File: rtl/cmd_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : cmd_uart_tx
// Brief    : Maps 3-bit motor command codes to ASCII 'a'..'e' and sends them
//            as UART 8N1, LSB first, with a one-deep latest-wins pending slot.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_uart_tx #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int BAUD            = 115200,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] CMD_STAT,
    input  logic       CMD_VALID,
    output logic       TX,
    output logic       BUSY,
    output logic       TX_DONE,
    output logic       CMD_ERR
);

    localparam int C_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int C_CNT_W        = (C_CLKS_PER_BIT > 1) ? $clog2(C_CLKS_PER_BIT) : 1;
    localparam logic [C_CNT_W-1:0] C_BAUD_LAST = C_CNT_W'(C_CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [C_CNT_W-1:0] r_baud;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         r_pend_byte;
    logic               r_pend_full;
    logic [2:0]         r_last_code;
    logic               r_tx;
    logic               r_cmd_err;

    logic               w_code_ok;
    logic [7:0]         w_byte;
    logic               w_repeat;
    logic               w_accept;
    logic               w_baud_last;
    logic               w_stop_end;
    logic               w_load;
    logic [7:0]         w_load_byte;
    logic               w_tx_next;

    always_comb begin
        w_code_ok = 1'b1;
        w_byte    = 8'h00;
        case (CMD_STAT)
            3'b001:  w_byte = 8'h61;
            3'b010:  w_byte = 8'h62;
            3'b011:  w_byte = 8'h63;
            3'b100:  w_byte = 8'h64;
            3'b101:  w_byte = 8'h65;
            default: w_code_ok = 1'b0;
        endcase
    end

    generate
        if (SUPPRESS_REPEAT != 0) begin : g_suppress
            assign w_repeat = (CMD_STAT == r_last_code);
        end else begin : g_no_suppress
            assign w_repeat = 1'b0;
        end
    endgenerate

    assign w_accept    = CMD_VALID & w_code_ok & ~w_repeat;
    assign w_baud_last = (r_baud == C_BAUD_LAST);
    assign w_stop_end  = (r_state == S_STOP) & w_baud_last;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_START;
            S_START: if (w_baud_last) w_state_next = S_DATA;
            S_DATA:  if (w_baud_last && r_idx == 3'd7) w_state_next = S_STOP;
            S_STOP:  if (w_baud_last) w_state_next = (w_accept || r_pend_full) ? S_START : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs and datapath controls; a fresh accept on the last stop clock beats the pending byte
    always_comb begin
        w_load      = ((r_state == S_IDLE) & w_accept) | (w_stop_end & (w_accept | r_pend_full));
        w_load_byte = w_accept ? w_byte : r_pend_byte;
        w_idx_next  = r_idx;
        if (r_state == S_START)
            w_idx_next = 3'd0;
        else if (r_state == S_DATA && w_baud_last)
            w_idx_next = r_idx + 3'd1;
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = r_shift[w_idx_next];
            default: w_tx_next = 1'b1;
        endcase
        BUSY    = (r_state != S_IDLE) | r_pend_full;
        TX_DONE = w_stop_end;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx        <= 1'b1;
            r_cmd_err   <= 1'b0;
            r_baud      <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_pend_byte <= 8'h00;
            r_pend_full <= 1'b0;
            r_last_code <= 3'b000;
        end else begin
            r_tx      <= w_tx_next;
            r_cmd_err <= CMD_VALID & ~w_code_ok;
            r_idx     <= w_idx_next;
            if (w_state_next != r_state || r_state == S_IDLE || w_baud_last)
                r_baud <= '0;
            else
                r_baud <= r_baud + 1'b1;
            if (w_load)
                r_shift <= w_load_byte;
            if (w_accept)
                r_last_code <= CMD_STAT;
            if (w_stop_end && (w_accept || r_pend_full)) begin
                r_pend_full <= 1'b0;
            end else if (w_accept && r_state != S_IDLE) begin
                r_pend_full <= 1'b1;
                r_pend_byte <= w_byte;
            end
        end
    end

    assign TX      = r_tx;
    assign CMD_ERR = r_cmd_err;

endmodule
`default_nettype wire
